// File: rtl/bus_pkg.sv
// Shared definitions for the CPU bus response path: FSM encoding, error causes,
// the default error read data and the memory map used by the address decoder.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_DECODE  = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'h0000_0000;

    localparam logic [31:0] IMEM_BASE  = 32'h0000_0000;
    localparam logic [31:0] IMEM_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] DMEM_BASE  = 32'h0000_1000;
    localparam logic [31:0] DMEM_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] ASCON_BASE = 32'h1000_0000;
    localparam logic [31:0] ASCON_MASK = 32'hFFFF_FF00;

    // A request is routable only when exactly one real slave is selected.
    function automatic logic sel_is_valid(input logic [2:0] sel, input logic invalid);
        return !invalid && ((sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100));
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating wait counter with synchronous clear; o_tc flags the last allowed
// wait cycle (count == TERMINAL-1).
module bus_timeout_counter #(
    parameter int TERMINAL = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = $clog2(TERMINAL);
    localparam logic [CW-1:0] LAST = CW'(TERMINAL - 1);

    logic [CW-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/bus_resp_collector.sv
// Collects the single outstanding slave response for a CPU request and turns
// decode/timeout failures into bus-error responses. Timeout enabled by BUS_TIMEOUT_EN.
module bus_resp_collector
    import bus_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic [31:0] cpu_req_addr,
    input  logic        sel_imem,
    input  logic        sel_dmem,
    input  logic        sel_ascon,
    input  logic        sel_invalid,
    input  logic        imem_rvalid,
    input  logic        dmem_rvalid,
    input  logic        ascon_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] dmem_rdata,
    input  logic [31:0] ascon_rdata,
    output logic        cpu_rsp_valid,
    output logic [31:0] cpu_rsp_rdata,
    output logic        cpu_rsp_err,
    output logic [31:0] err_addr,
    output logic [1:0]  err_cause
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_addr;
    logic [2:0]  r_sel;          // {ascon, dmem, imem}
    logic [31:0] r_rsp_rdata;
    logic [31:0] r_err_addr;
    logic [1:0]  r_err_cause;

    logic        w_accept;
    logic [2:0]  w_sel_in;
    logic        w_sel_rvalid;
    logic [31:0] w_sel_rdata;
    logic        w_timeout;
    logic        w_err_entry;

    assign w_sel_in = {sel_ascon, sel_dmem, sel_imem};
    assign w_accept = cpu_req_valid && (r_state == ST_IDLE);

    // Only the slave latched at acceptance is listened to.
    assign w_sel_rvalid = |(r_sel & {ascon_rvalid, dmem_rvalid, imem_rvalid});

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_sel_rdata = '0;
        if (r_sel[0]) w_sel_rdata = imem_rdata;
        if (r_sel[1]) w_sel_rdata = dmem_rdata;
        if (r_sel[2]) w_sel_rdata = ascon_rdata;
    end

`ifdef BUS_TIMEOUT_EN
    logic w_tc;

    bus_timeout_counter #(
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_accept),
        .i_en    (r_state == ST_WAIT),
        .o_tc    (w_tc)
    );

    assign w_timeout = w_tc;
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = sel_is_valid(w_sel_in, sel_invalid) ? ST_WAIT : ST_ERR;
                end
            end
            ST_WAIT: begin
                // A response in the terminal-count cycle beats the timeout.
                if (w_sel_rvalid)   w_state_nxt = ST_RESP;
                else if (w_timeout) w_state_nxt = ST_ERR;
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_err_entry = (w_state_nxt == ST_ERR) && (r_state != ST_ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_sel       <= '0;
            r_rsp_rdata <= '0;
            r_err_addr  <= '0;
            r_err_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr <= cpu_req_addr;
                r_sel  <= w_sel_in;
            end
            if ((r_state == ST_WAIT) && w_sel_rvalid) begin
                r_rsp_rdata <= w_sel_rdata;
            end else if (w_err_entry) begin
                r_rsp_rdata <= ERR_RDATA;
            end
            // Decode errors enter ERR straight from IDLE, before r_addr is loaded.
            if (w_err_entry) begin
                r_err_addr  <= (r_state == ST_IDLE) ? cpu_req_addr : r_addr;
                r_err_cause <= (r_state == ST_IDLE) ? CAUSE_DECODE : CAUSE_TIMEOUT;
            end
        end
    end

    assign cpu_req_ready = (r_state == ST_IDLE);
    assign cpu_rsp_valid = (r_state == ST_RESP) || (r_state == ST_ERR);
    assign cpu_rsp_err   = (r_state == ST_ERR);
    assign cpu_rsp_rdata = r_rsp_rdata;
    assign err_addr      = r_err_addr;
    assign err_cause     = r_err_cause;

endmodule

// File: tb/tb_bus_resp_collector.sv
// Directed self-checking bench for bus_resp_collector; timeout scenarios follow
// BUS_TIMEOUT_EN, otherwise WAIT is checked to persist until the slave answers.
module tb_bus_resp_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic [31:0] cpu_req_addr;
    logic        sel_imem, sel_dmem, sel_ascon, sel_invalid;
    logic        imem_rvalid, dmem_rvalid, ascon_rvalid;
    logic [31:0] imem_rdata, dmem_rdata, ascon_rdata;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rsp_rdata;
    logic        cpu_rsp_err;
    logic [31:0] err_addr;
    logic [1:0]  err_cause;

    int checks   = 0;
    int failures = 0;

    bus_resp_collector #(
        .TIMEOUT_CYCLES (64),
        .ERR_RDATA      (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_req_addr  (cpu_req_addr),
        .sel_imem      (sel_imem),
        .sel_dmem      (sel_dmem),
        .sel_ascon     (sel_ascon),
        .sel_invalid   (sel_invalid),
        .imem_rvalid   (imem_rvalid),
        .dmem_rvalid   (dmem_rvalid),
        .ascon_rvalid  (ascon_rvalid),
        .imem_rdata    (imem_rdata),
        .dmem_rdata    (dmem_rdata),
        .ascon_rdata   (ascon_rdata),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rsp_rdata (cpu_rsp_rdata),
        .cpu_rsp_err   (cpu_rsp_err),
        .err_addr      (err_addr),
        .err_cause     (err_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sel = {invalid, ascon, dmem, imem}; leaves the DUT one cycle past acceptance.
    task automatic request(input logic [31:0] addr, input logic [3:0] sel);
        check("req_ready_before_accept", cpu_req_ready, 1);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = addr;
        {sel_invalid, sel_ascon, sel_dmem, sel_imem} = sel;
        tick();
        cpu_req_valid = 1'b0;
        cpu_req_addr  = '0;
        {sel_invalid, sel_ascon, sel_dmem, sel_imem} = 4'b0000;
    endtask

    task automatic expect_idle_outputs(input string tag);
        check({tag, "_ready"}, cpu_req_ready, 1);
        check({tag, "_valid"}, cpu_rsp_valid, 0);
        check({tag, "_err"},   cpu_rsp_err,   0);
    endtask

    task automatic expect_err_rsp(input string tag, input logic [31:0] addr, input logic [1:0] cause);
        check({tag, "_valid"},     cpu_rsp_valid, 1);
        check({tag, "_err"},       cpu_rsp_err,   1);
        check({tag, "_rdata"},     cpu_rsp_rdata, 32'h0);
        check({tag, "_err_addr"},  err_addr,      addr);
        check({tag, "_err_cause"}, {30'b0, err_cause}, {30'b0, cause});
    endtask

    initial begin
        logic [31:0] exp_err_addr;
        logic [1:0]  exp_err_cause;
        int          stray_rsp;

        rst           = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_req_addr  = '0;
        {sel_invalid, sel_ascon, sel_dmem, sel_imem} = 4'b0000;
        {imem_rvalid, dmem_rvalid, ascon_rvalid}     = 3'b000;
        imem_rdata  = 32'hDEAD_0001;
        dmem_rdata  = 32'hDEAD_0002;
        ascon_rdata = 32'hDEAD_0003;
        tick();
        tick();
        expect_idle_outputs("reset");
        check("reset_rdata",     cpu_rsp_rdata, 32'h0);
        check("reset_err_addr",  err_addr, 32'h0);
        check("reset_err_cause", {30'b0, err_cause}, 32'h0);
        rst = 1'b0;
        tick();

        // DMEM read, rvalid in the third WAIT cycle, response one cycle later.
        request(32'h0000_1004, 4'b0010);
        check("dmem_wait1_ready", cpu_req_ready, 0);
        check("dmem_wait1_valid", cpu_rsp_valid, 0);
        tick();
        tick();
        check("dmem_wait3_valid", cpu_rsp_valid, 0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        tick();
        dmem_rvalid = 1'b0;
        check("dmem_rsp_valid", cpu_rsp_valid, 1);
        check("dmem_rsp_err",   cpu_rsp_err,   0);
        check("dmem_rsp_rdata", cpu_rsp_rdata, 32'h1234_5678);
        tick();
        expect_idle_outputs("dmem_after");
        check("dmem_rdata_held", cpu_rsp_rdata, 32'h1234_5678);

        // Decode errors: sel_invalid, two selects, no select.
        request(32'h2000_0000, 4'b1000);
        expect_err_rsp("dec_invalid", 32'h2000_0000, 2'b01);
        tick();
        expect_idle_outputs("dec_invalid_after");
        check("dec_invalid_rdata_held", cpu_rsp_rdata, 32'h0);

        request(32'h3000_0004, 4'b0011);
        expect_err_rsp("dec_multi", 32'h3000_0004, 2'b01);
        tick();
        request(32'h4000_0008, 4'b0000);
        expect_err_rsp("dec_none", 32'h4000_0008, 2'b01);
        tick();
        exp_err_addr  = 32'h4000_0008;
        exp_err_cause = 2'b01;

        // Stray imem_rvalid during a DMEM wait is ignored.
        request(32'h0000_1008, 4'b0010);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        check("stray_still_waiting", cpu_req_ready, 0);
        check("stray_no_rsp",        cpu_rsp_valid, 0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hAAAA_5555;
        tick();
        dmem_rvalid = 1'b0;
        check("stray_rsp_valid", cpu_rsp_valid, 1);
        check("stray_rsp_rdata", cpu_rsp_rdata, 32'hAAAA_5555);
        tick();

        // Back-to-back at minimum latency: accept in the first IDLE cycle.
        request(32'h0000_0040, 4'b0001);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0BAD_F00D;
        tick();
        imem_rvalid = 1'b0;
        check("b2b_rsp1_rdata", cpu_rsp_rdata, 32'h0BAD_F00D);
        tick();
        request(32'h1000_0004, 4'b0100);
        ascon_rvalid = 1'b1;
        ascon_rdata  = 32'h5A5A_0001;
        tick();
        ascon_rvalid = 1'b0;
        check("b2b_rsp2_valid", cpu_rsp_valid, 1);
        check("b2b_rsp2_rdata", cpu_rsp_rdata, 32'h5A5A_0001);
        tick();

`ifdef BUS_TIMEOUT_EN
        // ASCON timeout: WAIT cycles 1..64, error response in the next cycle.
        request(32'h1000_0010, 4'b0100);
        stray_rsp = 0;
        for (int i = 0; i < 63; i++) begin
            if (cpu_rsp_valid) stray_rsp++;
            tick();
        end
        check("to_wait64_no_rsp", cpu_rsp_valid, 0);
        check("to_wait_no_early_rsp", stray_rsp, 0);
        tick();
        expect_err_rsp("timeout", 32'h1000_0010, 2'b10);
        exp_err_addr  = 32'h1000_0010;
        exp_err_cause = 2'b10;
        tick();
        for (int i = 0; i < 4; i++) tick();
        ascon_rvalid = 1'b1;
        ascon_rdata  = 32'h1A7E_1A7E;
        tick();
        ascon_rvalid = 1'b0;
        expect_idle_outputs("late_rvalid");
        tick();
        check("late_rvalid_no_rsp", cpu_rsp_valid, 0);

        // rvalid in the terminal-count cycle wins over the timeout.
        request(32'h0000_0100, 4'b0001);
        for (int i = 0; i < 63; i++) tick();
        check("tc_race_wait64", cpu_req_ready, 0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        tick();
        imem_rvalid = 1'b0;
        check("tc_race_valid", cpu_rsp_valid, 1);
        check("tc_race_err",   cpu_rsp_err,   0);
        check("tc_race_rdata", cpu_rsp_rdata, 32'hCAFE_F00D);
        check("tc_race_cause", {30'b0, err_cause}, {30'b0, exp_err_cause});
        check("tc_race_addr",  err_addr, exp_err_addr);
        tick();
`else
        // No timeout: WAIT persists well past 64 cycles until the slave answers.
        request(32'h1000_0010, 4'b0100);
        stray_rsp = 0;
        for (int i = 0; i < 80; i++) begin
            if (cpu_rsp_valid || cpu_req_ready) stray_rsp++;
            tick();
        end
        check("noto_still_waiting", stray_rsp, 0);
        ascon_rvalid = 1'b1;
        ascon_rdata  = 32'h1A7E_1A7E;
        tick();
        ascon_rvalid = 1'b0;
        check("noto_rsp_valid", cpu_rsp_valid, 1);
        check("noto_rsp_err",   cpu_rsp_err,   0);
        check("noto_rsp_rdata", cpu_rsp_rdata, 32'h1A7E_1A7E);
        check("noto_cause",     {30'b0, err_cause}, {30'b0, exp_err_cause});
        check("noto_addr",      err_addr, exp_err_addr);
        tick();
`endif

        // Reset mid-WAIT abandons the transaction; later rvalid is dropped.
        request(32'h0000_1010, 4'b0010);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_idle_outputs("rst_wait");
        check("rst_wait_rdata",     cpu_rsp_rdata, 32'h0);
        check("rst_wait_err_addr",  err_addr, 32'h0);
        check("rst_wait_err_cause", {30'b0, err_cause}, 32'h0);
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h7777_8888;
        tick();
        dmem_rvalid = 1'b0;
        expect_idle_outputs("rst_late_rvalid");
        check("rst_late_rdata", cpu_rsp_rdata, 32'h0);
        tick();
        check("rst_late_no_rsp", cpu_rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_resp_collector.md
BUS_RESP_COLLECTOR -- requirements
Module: bus_resp_collector

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of WAIT cycles before a timeout error.
REQ-002 SHALL have parameter ERR_RDATA, default 32'h0000_0000, meaning the read data returned on any error response.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 cpu_req_valid  input  1  the CPU request is valid.
REQ-006 cpu_req_ready  output  1  the collector can accept a request.
REQ-007 cpu_req_addr  input  32  the request address.
REQ-008 sel_imem, sel_dmem, sel_ascon, sel_invalid  input  1 each  the one-hot decode of cpu_req_addr.
REQ-009 imem_rvalid, dmem_rvalid, ascon_rvalid  input  1 each  the slave response strobes.
REQ-010 imem_rdata, dmem_rdata, ascon_rdata  input  32 each  the slave response data.
REQ-011 cpu_rsp_valid  output  1  the response is valid; it is a one-cycle pulse.
REQ-012 cpu_rsp_rdata  output  32  the response data.
REQ-013 cpu_rsp_err  output  1  the response is a bus error.
REQ-014 err_addr  output  32  the address of the most recent errored request (sticky).
REQ-015 err_cause  output  2  the cause of the most recent error: 00 none, 01 decode, 10 timeout.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT, RESP and ERR.
REQ-017 cpu_req_ready SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted when cpu_req_valid and cpu_req_ready are both 1 in the same cycle.
REQ-019 On acceptance, the collector SHALL latch cpu_req_addr and the select vector.
REQ-020 After acceptance, the FSM SHALL go to WAIT if exactly one of sel_imem, sel_dmem or sel_ascon is 1; otherwise it SHALL go to ERR with cause 01.
REQ-021 The ERR entry condition in REQ-020 includes sel_invalid=1, all selects 0, and more than one select at 1.
REQ-022 In WAIT, only the latched slave's rvalid SHALL be observed; rvalid from unselected slaves SHALL be ignored.
REQ-023 When the latched slave's rvalid=1 in WAIT, its rdata SHALL be registered and the next state SHALL be RESP.
REQ-024 In RESP, cpu_rsp_valid=1, cpu_rsp_err=0 and cpu_rsp_rdata equals the captured data, for exactly one cycle; the next state SHALL be IDLE.
REQ-025 In ERR, cpu_rsp_valid=1, cpu_rsp_err=1 and cpu_rsp_rdata=ERR_RDATA, for exactly one cycle; the next state SHALL be IDLE.
REQ-026 On ERR entry, err_addr and err_cause SHALL be updated.
REQ-027 Latency: the response SHALL appear 1 cycle after the slave's rvalid, and 1 cycle after acceptance for a decode error.
REQ-028 The wait counter SHALL clear on acceptance and increment each WAIT cycle, saturating at TIMEOUT_CYCLES-1.
REQ-029 Timeout: in WAIT with counter=TIMEOUT_CYCLES-1 and no rvalid, the next state SHALL be ERR with cause 10.
REQ-030 If rvalid arrives in the same cycle as the timeout terminal count, rvalid SHALL win and no error SHALL be raised.
REQ-031 rvalid arriving in IDLE, RESP or ERR, for example a late response after a timeout, SHALL be discarded.
REQ-032 A new request SHALL be accepted in the first cycle back in IDLE, giving back-to-back throughput of 1 request per 3 cycles at minimum latency.
REQ-033 cpu_rsp_valid and cpu_rsp_err SHALL be 0 in IDLE and WAIT.
REQ-034 cpu_rsp_rdata SHALL hold its last value outside RESP and ERR.

Reset
REQ-035 When rst=1 at a clock edge, the FSM SHALL go to IDLE and the counter SHALL clear.
REQ-036 Under reset, cpu_req_ready SHALL read 1 (IDLE); cpu_rsp_valid=0, cpu_rsp_err=0, cpu_rsp_rdata=0, err_addr=0 and err_cause=00.
REQ-037 Reset during WAIT SHALL abandon the transaction with no response; any later rvalid for it SHALL be ignored per REQ-031.

Configuration
REQ-038 The timeout feature SHALL be controlled by the macro BUS_TIMEOUT_EN.
REQ-039 With BUS_TIMEOUT_EN defined, REQ-028 to REQ-030 SHALL apply.
REQ-040 Without BUS_TIMEOUT_EN, the counter logic SHALL be absent, WAIT SHALL persist until the selected rvalid, and cause 10 SHALL never be produced.

Structure
REQ-041 A shared package bus_pkg SHALL hold: the state encoding, the err_cause codes (CAUSE_NONE, CAUSE_DECODE, CAUSE_TIMEOUT), the default ERR_RDATA, and the memory-map base/mask constants shared with the decoder.
REQ-042 The timeout counter SHALL be one sub-module, bus_timeout_counter, with clear, enable and a terminal-count output; it SHALL be instantiated only under BUS_TIMEOUT_EN.

Verification
REQ-043 Scenario: DMEM read 0x0000_1004, dmem_rvalid after 3 cycles with rdata 0x1234_5678 -> one-cycle cpu_rsp_valid, rdata 0x1234_5678, err=0, exactly 1 cycle after rvalid.
REQ-044 Scenario: request to 0x2000_0000 (sel_invalid) -> rsp_valid, err=1 and rdata=0 on the next cycle; err_addr=0x2000_0000, err_cause=01.
REQ-045 Scenario: ASCON request 0x1000_0010 with no rvalid and TIMEOUT_CYCLES=64 -> error response at WAIT cycle 64 with cause 10; a late ascon_rvalid 5 cycles later produces no response.
REQ-046 Scenario: imem_rvalid in the exact cycle of the timeout terminal count -> normal response, err=0, err_cause unchanged.
REQ-047 Scenario: DMEM request with an imem_rvalid pulse during WAIT and then dmem_rvalid with rdata 0xAAAA_5555 -> response data 0xAAAA_5555 and the stray pulse is ignored.
REQ-048 Scenario: rst asserted for 1 cycle mid-WAIT followed by a delayed dmem_rvalid -> no response, cpu_req_ready=1 after reset, and all outputs at reset values.
